// File: rtl/time_uart_tx_pkg.sv
// Shared constants, FSM state type and helpers for the time-of-day UART line transmitter.
// Imported by the serializer and the top level.
package time_uart_pkg;

   localparam logic [7:0] COLON  = 8'h3A;
   localparam logic [7:0] SPACE  = 8'h20;
   localparam logic [7:0] CHAR_A = 8'h41;
   localparam logic [7:0] CHAR_P = 8'h50;
   localparam logic [7:0] CHAR_M = 8'h4D;
   localparam logic [7:0] CR     = 8'h0D;
   localparam logic [7:0] LF     = 8'h0A;
   localparam logic [7:0] QMARK  = 8'h3F;
   localparam logic [7:0] ZERO   = 8'h30;

   localparam int         LINE_CHARS = 13;
   localparam logic [3:0] LAST_IDX   = 4'(LINE_CHARS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic       pm;
   } time_snap_t;

   // Non-decimal nibbles are shown as '?' so a corrupt clock value is visible on the terminal.
   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
      logic [7:0] w_res;
      if (nib <= 4'd9) begin
         w_res = ZERO + {4'd0, nib};
      end else begin
         w_res = QMARK;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/time_uart_tx_if.sv
// Bundle of the clock-time inputs and serial/status outputs of time_uart_tx.
// master = the clock side and observer, slave = the transmitter.
interface time_uart_tx_if;
   logic       ena;
   logic       req;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       pm;
   logic       tx;
   logic       busy;
   logic       overrun;

   modport master (
      output ena, req, hh, mm, ss, pm,
      input  tx, busy, overrun
   );

   modport slave (
      input  ena, req, hh, mm, ss, pm,
      output tx, busy, overrun
   );
endinterface

// File: rtl/time_uart_tx_byte.sv
// 8N1 byte serializer. ready is high when a byte can be accepted this cycle, including the
// last cycle of a stop bit, so a following start bit goes out with no idle gap.
module uart_tx_byte
   import time_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   tx_state_e   r_state;
   tx_state_e   w_state_nxt;
   logic [15:0] r_clk_cnt;
   logic [15:0] w_clk_cnt_nxt;
   logic [2:0]  r_bit_cnt;
   logic [2:0]  w_bit_cnt_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic        r_tx;
   logic        w_tx_nxt;
   logic        w_bit_end;

   assign w_bit_end = (r_clk_cnt == LAST_CNT);
   assign ready     = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
   assign tx        = r_tx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_clk_cnt <= 16'd0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
      end
   end

   // tx is computed one cycle ahead so the line pin comes straight from a flop.
   always_comb begin
      w_state_nxt   = r_state;
      w_clk_cnt_nxt = w_bit_end ? 16'd0 : (r_clk_cnt + 16'd1);
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_tx_nxt      = r_tx;
      case (r_state)
         IDLE: begin
            w_clk_cnt_nxt = 16'd0;
            if (start) begin
               w_state_nxt = START;
               w_shift_nxt = data;
               w_tx_nxt    = 1'b0;
            end else begin
               w_tx_nxt    = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = 3'd0;
               w_tx_nxt      = r_shift[0];
            end else begin
               w_tx_nxt      = 1'b0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt   = STOP;
                  w_tx_nxt      = 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_tx_nxt      = r_shift[1];
               end
            end else begin
               w_tx_nxt = r_shift[0];
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (start) begin
                  w_state_nxt = START;
                  w_shift_nxt = data;
                  w_tx_nxt    = 1'b0;
               end else begin
                  w_state_nxt = IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end else begin
               w_tx_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_clk_cnt_nxt = 16'd0;
            w_tx_nxt      = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/time_uart_tx.sv
// Sends the current BCD time as "HH:MM:SS AM\r\n" over UART on each seconds change or request.
// Holds the snapshot, character index, character mux and trigger/overrun logic.
module time_uart_tx
   import time_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input logic           clk,
   input logic           reset,
   time_uart_tx_if.slave bus
);

   logic [7:0] r_ss_q;
   time_snap_t r_snap;
   logic [3:0] r_idx;
   logic       r_busy;
   logic       r_overrun;

   time_snap_t w_live;
   time_snap_t w_src;
   logic [3:0] w_char_idx;
   logic [7:0] w_char;
   logic       w_trigger;
   logic       w_launch;
   logic       w_advance;
   logic       w_start;
   logic       w_ready;
   logic       w_tx;

   assign w_live    = '{hh: bus.hh, mm: bus.mm, ss: bus.ss, pm: bus.pm};
   assign w_trigger = (bus.ena && (bus.ss != r_ss_q)) || bus.req;
   assign w_launch  = w_trigger && !r_busy;
   assign w_advance = r_busy && w_ready && (r_idx < LAST_IDX);
   assign w_start   = w_launch || w_advance;

   // Character 0 is launched from the live inputs, since the snapshot loads on that same edge.
   always_comb begin
      w_src      = r_snap;
      w_char_idx = r_idx + 4'd1;
      w_char     = SPACE;
      if (r_busy) begin
         w_src      = r_snap;
         w_char_idx = r_idx + 4'd1;
      end else begin
         w_src      = w_live;
         w_char_idx = 4'd0;
      end
      case (w_char_idx)
         4'd0:    w_char = bcd_to_ascii(w_src.hh[7:4]);
         4'd1:    w_char = bcd_to_ascii(w_src.hh[3:0]);
         4'd2:    w_char = COLON;
         4'd3:    w_char = bcd_to_ascii(w_src.mm[7:4]);
         4'd4:    w_char = bcd_to_ascii(w_src.mm[3:0]);
         4'd5:    w_char = COLON;
         4'd6:    w_char = bcd_to_ascii(w_src.ss[7:4]);
         4'd7:    w_char = bcd_to_ascii(w_src.ss[3:0]);
         4'd8:    w_char = SPACE;
         4'd9:    w_char = w_src.pm ? CHAR_P : CHAR_A;
         4'd10:   w_char = CHAR_M;
         4'd11:   w_char = CR;
         4'd12:   w_char = LF;
         default: w_char = SPACE;
      endcase
   end

   // ss_q tracks ss even in reset, so a value already present at release does not send.
   always_ff @(posedge clk) begin
      r_ss_q <= bus.ss;
      if (reset) begin
         r_snap    <= time_snap_t'(25'd0);
         r_idx     <= 4'd0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_trigger && r_busy;
         if (w_launch) begin
            r_snap <= w_live;
            r_idx  <= 4'd0;
            r_busy <= 1'b1;
         end else if (w_advance) begin
            r_idx  <= r_idx + 4'd1;
         end else if (r_busy && w_ready) begin
            r_idx  <= 4'd0;
            r_busy <= 1'b0;
         end else begin
            r_idx  <= r_idx;
            r_busy <= r_busy;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk  (clk),
      .reset(reset),
      .start(w_start),
      .data (w_char),
      .tx   (w_tx),
      .ready(w_ready)
   );

   assign bus.tx      = w_tx;
   assign bus.busy    = r_busy;
   assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_time_uart_tx.sv
// Directed bench for time_uart_tx: decodes the serial line with a bit-timed receiver and
// compares against hand-written ASCII lines, plus busy/overrun/reset sequences.
module tb_time_uart_tx;

   localparam int CPB        = 4;
   localparam int LINE_CYCLES = 13 * 10 * CPB;

   typedef struct {
      logic [7:0]   hh;
      logic [7:0]   mm;
      logic [7:0]   ss0;
      logic [7:0]   ss;
      logic         pm;
      logic         use_req;
      logic [103:0] exp_line;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   time_uart_tx_if bus();

   time_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int busy_cnt  = 0;
   int txlow_cnt = 0;
   int ovr_cnt   = 0;

   logic [7:0] rx [13];
   int         rx_err;

   always @(negedge clk) begin
      if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
      if (bus.tx !== 1'b1) txlow_cnt <= txlow_cnt + 1;
      if (bus.overrun !== 1'b0) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call just after the launch edge; returns at the negedge in the last cycle of the final stop bit.
   task automatic recv_line(input logic scramble);
      logic s;
      rx_err = 0;
      for (int c = 0; c < 13; c++) begin
         for (int b = 0; b < 10; b++) begin
            repeat (2) @(negedge clk);
            s = bus.tx;
            if (b == 0) begin
               if (s !== 1'b0) rx_err++;
            end else if (b == 9) begin
               if (s !== 1'b1) rx_err++;
            end else begin
               rx[c][b-1] = s;
            end
            if (scramble && c == 3 && b == 0) begin
               bus.hh = 8'h99;
               bus.mm = 8'h88;
               bus.ss = 8'h33;
               bus.pm = ~bus.pm;
            end
            repeat (2) @(negedge clk);
         end
      end
   endtask

   function automatic logic [103:0] rx_packed();
      logic [103:0] r;
      r = 104'd0;
      for (int c = 0; c < 13; c++) r[103-8*c -: 8] = rx[c];
      return r;
   endfunction

   vec_t vecs [4];

   initial begin
      int b0;
      int t0;
      int o0;

      vecs[0] = '{8'h11, 8'h59, 8'h58, 8'h59, 1'b0, 1'b0,
                  104'h31_31_3A_35_39_3A_35_39_20_41_4D_0D_0A};
      vecs[1] = '{8'h12, 8'h00, 8'h07, 8'h07, 1'b1, 1'b1,
                  104'h31_32_3A_30_30_3A_30_37_20_50_4D_0D_0A};
      vecs[2] = '{8'h03, 8'h5C, 8'h41, 8'h41, 1'b0, 1'b1,
                  104'h30_33_3A_35_3F_3A_34_31_20_41_4D_0D_0A};
      vecs[3] = '{8'h10, 8'h47, 8'h22, 8'h23, 1'b1, 1'b0,
                  104'h31_30_3A_34_37_3A_32_33_20_50_4D_0D_0A};

      // Reset, with ss moving to 05 while reset is held
      reset   = 1'b1;
      bus.ena = 1'b0;
      bus.req = 1'b0;
      bus.hh  = 8'h01;
      bus.mm  = 8'h00;
      bus.ss  = 8'h00;
      bus.pm  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.ss = 8'h05;
      @(posedge clk); #1;
      check("reset_tx", bus.tx, 1'b1);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_overrun", bus.overrun, 1'b0);
      @(negedge clk);
      reset   = 1'b0;
      bus.ena = 1'b1;
      #1;
      b0 = busy_cnt; t0 = txlow_cnt; o0 = ovr_cnt;
      repeat (1000) @(negedge clk);
      #1;
      check("idle_busy", busy_cnt - b0, 0);
      check("idle_txlow", txlow_cnt - t0, 0);
      check("idle_overrun", ovr_cnt - o0, 0);

      // Table of complete lines
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.ena = 1'b0;
         bus.req = 1'b0;
         bus.hh  = vecs[i].hh;
         bus.mm  = vecs[i].mm;
         bus.ss  = vecs[i].ss0;
         bus.pm  = vecs[i].pm;
         repeat (3) @(negedge clk);
         if (vecs[i].use_req) begin
            bus.req = 1'b1;
         end else begin
            bus.ena = 1'b1;
            bus.ss  = vecs[i].ss;
         end
         @(posedge clk); #1;
         bus.req = 1'b0;
         bus.ena = 1'b0;
         check($sformatf("v%0d_launch_tx", i), bus.tx, 1'b0);
         check($sformatf("v%0d_launch_busy", i), bus.busy, 1'b1);
         b0 = busy_cnt; o0 = ovr_cnt;
         recv_line(1'b1);
         for (int c = 0; c < 13; c++)
            check($sformatf("v%0d_char%0d", i, c), rx[c], vecs[i].exp_line[103-8*c -: 8]);
         check($sformatf("v%0d_frame", i), rx_err, 0);
         @(posedge clk); #1;
         check($sformatf("v%0d_busy_end", i), bus.busy, 1'b0);
         check($sformatf("v%0d_tx_end", i), bus.tx, 1'b1);
         check($sformatf("v%0d_busy_len", i), busy_cnt - b0, LINE_CYCLES);
         check($sformatf("v%0d_overrun", i), ovr_cnt - o0, 0);
      end

      // req 100 cycles into a line, then a trigger in the busy-fall cycle
      @(negedge clk);
      bus.hh = 8'h12; bus.mm = 8'h00; bus.ss = 8'h07; bus.pm = 1'b1;
      repeat (3) @(negedge clk);
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      check("ovr_launch", bus.tx, 1'b0);
      b0 = busy_cnt; o0 = ovr_cnt;
      fork
         recv_line(1'b0);
         begin
            repeat (100) @(negedge clk);
            bus.req = 1'b1;
            @(negedge clk);
            bus.req = 1'b0;
         end
      join
      check("ovr_line", rx_packed(), vecs[1].exp_line);
      check("ovr_frame", rx_err, 0);
      check("ovr_pulse", ovr_cnt - o0, 1);
      bus.req = 1'b1;
      @(posedge clk); #1;
      check("edge_busy_fall", bus.busy, 1'b0);
      check("edge_busy_len", busy_cnt - b0, LINE_CYCLES);
      @(negedge clk);
      bus.req = 1'b0;
      #1;
      check("edge_overrun", ovr_cnt - o0, 2);
      b0 = busy_cnt; t0 = txlow_cnt;
      repeat (60) @(negedge clk);
      #1;
      check("edge_no_line_busy", busy_cnt - b0, 0);
      check("edge_no_line_tx", txlow_cnt - t0, 0);

      // Trigger one cycle after busy falls starts a new line
      @(negedge clk);
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      recv_line(1'b0);
      @(posedge clk); #1;
      check("next_busy_fall", bus.busy, 1'b0);
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      check("next_launch_tx", bus.tx, 1'b0);
      check("next_launch_busy", bus.busy, 1'b1);

      // Reset 200 cycles into that line, together with a req
      repeat (200) @(negedge clk);
      reset   = 1'b1;
      bus.req = 1'b1;
      @(posedge clk); #1;
      check("midrst_tx", bus.tx, 1'b1);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_overrun", bus.overrun, 1'b0);
      @(negedge clk);
      reset   = 1'b0;
      bus.req = 1'b0;
      #1;
      b0 = busy_cnt; t0 = txlow_cnt; o0 = ovr_cnt;
      repeat (1000) @(negedge clk);
      #1;
      check("postrst_busy", busy_cnt - b0, 0);
      check("postrst_txlow", txlow_cnt - t0, 0);
      check("postrst_overrun", ovr_cnt - o0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
